// File: rtl/mips_pkg.sv
// mips_pkg: funct codes and the multiply/divide sequencer state type.
// Shared by the ALU, the decoder and muldiv_seq.
package mips_pkg;

   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

endpackage

// File: rtl/muldiv_dp.sv
// muldiv_dp: shift-add multiply / restoring divide iterations on operand magnitudes.
// Divide registers and result muxing are built only when MULDIV_DIV_EN is defined.
module muldiv_dp #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
`ifdef MULDIV_DIV_EN
   input  logic                  i_div,
   output logic                  o_dbz,
`endif
   input  logic                  i_load,
   input  logic                  i_step,
   input  logic                  i_signed,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo
);
   localparam int W = DATA_WIDTH;

   function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   logic [W-1:0] r_acc;
   logic [W-1:0] r_q;
   logic [W-1:0] r_m;
   logic         r_neg_lo;
   logic         w_sa;
   logic         w_sb;
   logic [W:0]   w_sum;
   logic [W-1:0] w_acc_nxt;
   logic [W-1:0] w_q_nxt;
`ifdef MULDIV_DIV_EN
   logic         r_div;
   logic         r_dbz;
   logic         r_neg_hi;
   logic [W-1:0] r_a;
   logic [W:0]   w_shift;
   logic [W:0]   w_diff;
`endif

   assign w_sa = i_signed & i_a[W-1];
   assign w_sb = i_signed & i_b[W-1];

   // r_q starts as the multiplier (multiply) or dividend (divide); r_m is the other operand
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_acc    <= '0;
         r_q      <= cond_neg(i_a, w_sa);
         r_m      <= cond_neg(i_b, w_sb);
         r_neg_lo <= w_sa ^ w_sb;
`ifdef MULDIV_DIV_EN
         r_div    <= i_div;
         r_dbz    <= i_div && (i_b == '0);
         r_neg_hi <= w_sa;
         r_a      <= i_a;
`endif
      end else if (i_step) begin
         r_acc <= w_acc_nxt;
         r_q   <= w_q_nxt;
      end
   end

   always_comb begin
      w_sum = {1'b0, r_acc} + {1'b0, r_m};
      if (r_q[0]) {w_acc_nxt, w_q_nxt} = {w_sum, r_q[W-1:1]};
      else        {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[W-1:1]};
`ifdef MULDIV_DIV_EN
      w_shift = {r_acc, r_q[W-1]};
      w_diff  = w_shift - {1'b0, r_m};
      if (r_div) begin
         if (!w_diff[W]) begin
            w_acc_nxt = w_diff[W-1:0];
            w_q_nxt   = {r_q[W-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shift[W-1:0];
            w_q_nxt   = {r_q[W-2:0], 1'b0};
         end
      end
`endif
   end

   // Sign correction: whole product, or quotient/remainder separately
   always_comb begin
      {o_hi, o_lo} = cond_neg2({r_acc, r_q}, r_neg_lo);
`ifdef MULDIV_DIV_EN
      o_dbz = r_dbz;
      if (r_div) begin
         if (r_dbz) begin
            o_hi = r_a;
            o_lo = '1;
         end else begin
            o_hi = cond_neg(r_acc, r_neg_hi);
            o_lo = cond_neg(r_q, r_neg_lo);
         end
      end
`endif
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning architectural HI/LO.
// Define MULDIV_DIV_EN to build the divide path; otherwise DIV/DIVU decode as no-ops.
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FUNC_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [FUNC_WIDTH-1:0] func,
   input  logic [DATA_WIDTH-1:0] op_A,
   input  logic [DATA_WIDTH-1:0] op_B,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  div_by_zero
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   state_e                r_state;
   state_e                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_hi;
   logic [DATA_WIDTH-1:0] r_lo;
   logic                  w_accept;
   logic                  w_is_mul;
   logic                  w_is_div;
   logic                  w_is_signed;
   logic                  w_start;
   logic [DATA_WIDTH-1:0] w_res_hi;
   logic [DATA_WIDTH-1:0] w_res_lo;
`ifdef MULDIV_DIV_EN
   logic                  r_dbz;
   logic                  w_res_dbz;
`endif

   assign w_accept    = op_valid && op_ready && !abort;
   assign w_is_mul    = (func == FUNC_WIDTH'(FN_MULT)) || (func == FUNC_WIDTH'(FN_MULTU));
`ifdef MULDIV_DIV_EN
   assign w_is_div    = (func == FUNC_WIDTH'(FN_DIV)) || (func == FUNC_WIDTH'(FN_DIVU));
`else
   assign w_is_div    = 1'b0;
`endif
   assign w_is_signed = (func == FUNC_WIDTH'(FN_MULT)) || (func == FUNC_WIDTH'(FN_DIV));
   assign w_start     = w_accept && (w_is_mul || w_is_div);

   muldiv_dp #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_dp (
      .clk      (clk),
`ifdef MULDIV_DIV_EN
      .i_div    (w_is_div),
      .o_dbz    (w_res_dbz),
`endif
      .i_load   (w_start),
      .i_step   (r_state == CALC),
      .i_signed (w_is_signed),
      .i_a      (op_A),
      .i_b      (op_B),
      .o_hi     (w_res_hi),
      .o_lo     (w_res_lo)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = CALC;
         CALC: begin
            if (abort)              w_next = IDLE;
            else if (r_cnt == '0)   w_next = FIX;
         end
         FIX:     w_next = abort ? IDLE : DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // HI/LO commit on the FIX->DONE edge, so an abort seen in DONE is too late to cancel it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
`ifdef MULDIV_DIV_EN
         r_dbz   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_start)
            r_cnt <= CNT_W'(DATA_WIDTH - 1);
         else if (r_state == CALC && r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
         if (w_accept && func == FUNC_WIDTH'(FN_MTHI)) r_hi <= op_A;
         if (w_accept && func == FUNC_WIDTH'(FN_MTLO)) r_lo <= op_A;
         if (r_state == FIX && !abort) begin
            r_hi  <= w_res_hi;
            r_lo  <= w_res_lo;
`ifdef MULDIV_DIV_EN
            r_dbz <= w_res_dbz;
`endif
         end
      end
   end

   assign op_ready = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign hi       = r_hi;
   assign lo       = r_lo;
`ifdef MULDIV_DIV_EN
   assign div_by_zero = r_dbz;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;
   import mips_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic        vld;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic        op_ready;
   logic [5:0]  func;
   logic [31:0] op_A;
   logic [31:0] op_B;
   logic        abort;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int   n_pass = 0;
   int   n_chk  = 0;
   exp_t sb_q[$];

   muldiv_seq #(.DATA_WIDTH(W), .FUNC_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .func(func),
      .op_A(op_A), .op_B(op_B), .abort(abort), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] pu;
      logic signed [63:0] ps;
      e = '0;
      case (f)
         FN_MULTU: begin
            pu = {32'b0, a} * {32'b0, b};
            e.vld = 1'b1; e.hi = pu[63:32]; e.lo = pu[31:0];
         end
         FN_MULT: begin
            ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e.vld = 1'b1; e.hi = ps[63:32]; e.lo = ps[31:0];
         end
`ifdef MULDIV_DIV_EN
         FN_DIVU, FN_DIV: begin
            e.vld = 1'b1;
            if (b == 32'd0) begin
               e.lo = 32'hFFFFFFFF; e.hi = a; e.dbz = 1'b1;
            end else if (f == FN_DIVU) begin
               e.lo = a / b; e.hi = a % b;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               e.lo = 32'h80000000; e.hi = 32'd0;
            end else begin
               e.lo = $signed(a) / $signed(b); e.hi = $signed(a) % $signed(b);
            end
         end
`endif
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1; func = f; op_A = a; op_B = b;
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   // Watches W+8 edges after an accept; lat is the edge index of the first done (-1 if none).
   task automatic observe(output int lat, output logic [31:0] h, output logic [31:0] l,
                          output logic z, output int nd);
      lat = -1; h = '0; l = '0; z = 1'b0; nd = 0;
      for (int k = 1; k <= W + 8; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) begin lat = k; h = hi; l = lo; z = div_by_zero; end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; op_valid = 1'b0; abort = 1'b0; func = '0; op_A = '0; op_B = '0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want %h", hi, 32'd0); else n_pass++;
      n_chk++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want %h", lo, 32'd0); else n_pass++;
      n_chk++; if (op_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", op_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_chk++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_arith();
      logic [5:0]  fv[12];
      logic [31:0] av[12], bv[12], eh[6], el[6];
      logic        ez[6];
      exp_t        e;
      int          lat, nd;
      logic [31:0] h, l, ph, pl;
      logic        z;
      fv[0] = FN_MULTU; av[0] = 32'hFFFFFFFF; bv[0] = 32'hFFFFFFFF; eh[0] = 32'hFFFFFFFE; el[0] = 32'h00000001; ez[0] = 1'b0;
      fv[1] = FN_MULT;  av[1] = 32'hFFFFFFFD; bv[1] = 32'd7;        eh[1] = 32'hFFFFFFFF; el[1] = 32'hFFFFFFEB; ez[1] = 1'b0;
      fv[2] = FN_DIV;   av[2] = 32'hFFFFFFF9; bv[2] = 32'd2;        eh[2] = 32'hFFFFFFFF; el[2] = 32'hFFFFFFFD; ez[2] = 1'b0;
      fv[3] = FN_DIVU;  av[3] = 32'd100;      bv[3] = 32'd0;        eh[3] = 32'd100;      el[3] = 32'hFFFFFFFF; ez[3] = 1'b1;
      fv[4] = FN_DIV;   av[4] = 32'h80000000; bv[4] = 32'hFFFFFFFF; eh[4] = 32'd0;        el[4] = 32'h80000000; ez[4] = 1'b0;
      fv[5] = FN_DIV;   av[5] = 32'hFFFFFFFB; bv[5] = 32'd0;        eh[5] = 32'hFFFFFFFB; el[5] = 32'hFFFFFFFF; ez[5] = 1'b1;
      for (int i = 6; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0:       fv[i] = FN_MULT;
            1:       fv[i] = FN_MULTU;
            2:       fv[i] = FN_DIV;
            default: fv[i] = FN_DIVU;
         endcase
         av[i] = $urandom;
         bv[i] = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
      end
      for (int i = 0; i < 12; i++) begin
         e = model(fv[i], av[i], bv[i]);
         if (i < 6) begin e.hi = eh[i]; e.lo = el[i]; e.dbz = ez[i]; end
         ph = hi; pl = lo;
         sb_q.push_back(e);
         issue(fv[i], av[i], bv[i]);
         n_chk++; if (busy !== e.vld) $display("FAIL arith[%0d]_busy got %b want %b", i, busy, e.vld); else n_pass++;
         observe(lat, h, l, z, nd);
         e = sb_q.pop_front();
         if (e.vld) begin
            n_chk++; if (lat !== W + 1) $display("FAIL arith[%0d]_latency got %0d want %0d", i, lat, W + 1); else n_pass++;
            n_chk++; if (nd !== 1) $display("FAIL arith[%0d]_done_cycles got %0d want 1", i, nd); else n_pass++;
            n_chk++; if (h !== e.hi) $display("FAIL arith[%0d]_hi got %h want %h", i, h, e.hi); else n_pass++;
            n_chk++; if (l !== e.lo) $display("FAIL arith[%0d]_lo got %h want %h", i, l, e.lo); else n_pass++;
            n_chk++; if (z !== e.dbz) $display("FAIL arith[%0d]_dbz got %b want %b", i, z, e.dbz); else n_pass++;
         end else begin
            n_chk++; if (nd !== 0) $display("FAIL arith[%0d]_nodone got %0d want 0", i, nd); else n_pass++;
            n_chk++; if (hi !== ph) $display("FAIL arith[%0d]_hi_kept got %h want %h", i, hi, ph); else n_pass++;
            n_chk++; if (lo !== pl) $display("FAIL arith[%0d]_lo_kept got %h want %h", i, lo, pl); else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      int          lat, nd;
      logic [31:0] h, l, ph, pl;
      logic        z;
      op_valid = 1'b1; func = FN_MTLO; op_A = 32'h1234;
      @(posedge clk); #1;
      n_chk++; if (lo !== 32'h1234) $display("FAIL mtlo_lo got %h want %h", lo, 32'h1234); else n_pass++;
      n_chk++; if (op_ready !== 1'b1) $display("FAIL mtlo_ready got %b want 1", op_ready); else n_pass++;
      func = FN_MTHI; op_A = 32'h5678;
      @(posedge clk); #1;
      op_valid = 1'b0;
      n_chk++; if (hi !== 32'h5678) $display("FAIL mthi_hi got %h want %h", hi, 32'h5678); else n_pass++;
      n_chk++; if (lo !== 32'h1234) $display("FAIL mthi_lo got %h want %h", lo, 32'h1234); else n_pass++;
      n_chk++; if (op_ready !== 1'b1) $display("FAIL mthi_ready got %b want 1", op_ready); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL mthi_done got %b want 0", done); else n_pass++;
      // unrecognised func is swallowed without effect
      ph = hi; pl = lo;
      issue(6'h00, 32'hFFFF, 32'h3);
      n_chk++; if (busy !== 1'b0) $display("FAIL badfn_busy got %b want 0", busy); else n_pass++;
      observe(lat, h, l, z, nd);
      n_chk++; if (nd !== 0) $display("FAIL badfn_nodone got %0d want 0", nd); else n_pass++;
      n_chk++; if (hi !== ph || lo !== pl) $display("FAIL badfn_hilo got %h_%h want %h_%h", hi, lo, ph, pl); else n_pass++;
      // request held while busy is ignored, then taken once idle
      sb_q.push_back(model(FN_MULTU, 32'd3, 32'd4));
      issue(FN_MULTU, 32'd3, 32'd4);
      op_valid = 1'b1; func = FN_MTHI; op_A = 32'hDEAD;
      observe(lat, h, l, z, nd);
      op_valid = 1'b0;
      e = sb_q.pop_front();
      n_chk++; if (h !== e.hi) $display("FAIL busy_ignore_hi got %h want %h", h, e.hi); else n_pass++;
      n_chk++; if (l !== e.lo) $display("FAIL busy_ignore_lo got %h want %h", l, e.lo); else n_pass++;
      n_chk++; if (nd !== 1) $display("FAIL busy_ignore_done got %0d want 1", nd); else n_pass++;
      n_chk++; if (hi !== 32'hDEAD) $display("FAIL idle_accept_hi got %h want %h", hi, 32'hDEAD); else n_pass++;
   endtask

   task automatic test_abort();
      exp_t        e;
      int          lat, nd;
      logic [31:0] h, l, ph, pl;
      logic        z;
      ph = hi; pl = lo;
      issue(FN_MULT, 32'd5, 32'd6);
      repeat (9) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_chk++; if (op_ready !== 1'b1) $display("FAIL abort_calc_ready got %b want 1", op_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL abort_calc_busy got %b want 0", busy); else n_pass++;
      observe(lat, h, l, z, nd);
      n_chk++; if (nd !== 0) $display("FAIL abort_calc_nodone got %0d want 0", nd); else n_pass++;
      n_chk++; if (hi !== ph || lo !== pl) $display("FAIL abort_calc_hilo got %h_%h want %h_%h", hi, lo, ph, pl); else n_pass++;
      // abort in FIX
      issue(FN_MULTU, 32'd9, 32'd9);
      repeat (W) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_chk++; if (busy !== 1'b0) $display("FAIL abort_fix_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (hi !== ph || lo !== pl) $display("FAIL abort_fix_hilo got %h_%h want %h_%h", hi, lo, ph, pl); else n_pass++;
      observe(lat, h, l, z, nd);
      n_chk++; if (nd !== 0) $display("FAIL abort_fix_nodone got %0d want 0", nd); else n_pass++;
      // abort together with a request in IDLE blocks acceptance
      op_valid = 1'b1; abort = 1'b1; func = FN_MULTU; op_A = 32'd2; op_B = 32'd3;
      @(posedge clk); #1;
      func = FN_MTLO; op_A = 32'hABCD;
      @(posedge clk); #1;
      op_valid = 1'b0; abort = 1'b0;
      n_chk++; if (busy !== 1'b0) $display("FAIL abort_idle_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (lo !== pl) $display("FAIL abort_idle_mtlo got %h want %h", lo, pl); else n_pass++;
      observe(lat, h, l, z, nd);
      n_chk++; if (nd !== 0) $display("FAIL abort_idle_nodone got %0d want 0", nd); else n_pass++;
      // abort in DONE does not undo the commit
      sb_q.push_back(model(FN_MULTU, 32'd7, 32'd8));
      issue(FN_MULTU, 32'd7, 32'd8);
      repeat (W + 1) @(posedge clk);
      #1;
      n_chk++; if (done !== 1'b1) $display("FAIL abort_done_pulse got %b want 1", done); else n_pass++;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      e = sb_q.pop_front();
      n_chk++; if (hi !== e.hi || lo !== e.lo) $display("FAIL abort_done_hilo got %h_%h want %h_%h", hi, lo, e.hi, e.lo); else n_pass++;
      n_chk++; if (op_ready !== 1'b1) $display("FAIL abort_done_ready got %b want 1", op_ready); else n_pass++;
   endtask

   task automatic test_rst_mid();
      int          lat, nd;
      logic [31:0] h, l;
      logic        z;
      issue(FN_MULT, 32'd11, 32'd13);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1; abort = 1'b1; op_valid = 1'b1; func = FN_MTHI; op_A = 32'h1;
      @(posedge clk); #1;
      rst = 1'b0; abort = 1'b0; op_valid = 1'b0;
      n_chk++; if (op_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", op_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (hi !== 32'd0) $display("FAIL rst_mid_hi got %h want %h", hi, 32'd0); else n_pass++;
      n_chk++; if (lo !== 32'd0) $display("FAIL rst_mid_lo got %h want %h", lo, 32'd0); else n_pass++;
      observe(lat, h, l, z, nd);
      n_chk++; if (nd !== 0) $display("FAIL rst_mid_nodone got %0d want 0", nd); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_back_to_back();
      test_abort();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand, HI and LO width.
REQ-002 SHALL have parameter FUNC_WIDTH, default 6: width of the func code.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port op_valid  input  1: request present.
REQ-006 SHALL have port op_ready  output  1: request can be accepted this cycle.
REQ-007 SHALL have port func  input  FUNC_WIDTH: MIPS funct code (MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13).
REQ-008 SHALL have ports op_A and op_B, both input, DATA_WIDTH: op_A is rs or the dividend, op_B is rt or the divisor.
REQ-009 SHALL have port abort  input  1: pipeline flush; cancels the operation in flight.
REQ-010 SHALL have port busy  output  1: an iterative operation is in progress, so the pipeline stalls MFHI/MFLO.
REQ-011 SHALL have port done  output  1: one-cycle pulse when HI/LO take a multiply or divide result.
REQ-012 SHALL have ports hi and lo, both output, DATA_WIDTH: architectural HI and LO registers, read directly by MFHI/MFLO.
REQ-013 SHALL have port div_by_zero  output  1: qualified by done; divisor was zero.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX and DONE, with op_ready = (state==IDLE) and busy = (state!=IDLE).
REQ-015 SHALL accept a request when op_valid, op_ready and !abort are all high at a clock edge; operands and func are registered at that edge.
REQ-016 SHALL, for MTHI or MTLO, write op_A into hi or lo at the accepting edge, stay in IDLE and not assert done.
REQ-017 SHALL, for MULT, MULTU, DIV or DIVU, move IDLE->CALC and then run exactly DATA_WIDTH iteration cycles (5-bit down-counter for W=32).
REQ-018 SHALL move CALC->FIX after the last iteration, where FIX applies the sign correction for signed ops (negate product; quotient sign = sign(A) xor sign(B); remainder sign = sign(A)).
REQ-019 SHALL move FIX->DONE with HI/LO written at that edge, hold done high for the one DONE cycle, then move DONE->IDLE.
REQ-020 SHALL give a fixed latency: accept at edge 0 -> done high between edges W+1 and W+2, with hi/lo updated at edge W+1.
REQ-021 SHALL produce, for multiply, hi:lo = the full 2W-bit product (signed or unsigned per func).
REQ-022 SHALL produce, for divide, lo = quotient and hi = remainder by restoring division on magnitudes.
REQ-023 SHALL handle divide by zero as: lo = all ones, hi = op_A, div_by_zero=1 with done, same latency.
REQ-024 SHALL handle signed overflow (MIN / -1) as: lo = MIN, hi = 0, with no flag.
REQ-025 SHALL treat an unrecognised func as accepted but a no-op: stay IDLE, no done, HI/LO unchanged.
REQ-026 SHALL, on abort in CALC or FIX, go to IDLE at the next edge with HI/LO unchanged and no done.
REQ-027 SHALL, on abort in DONE, still commit the result, because the commit happened at the prior edge.
REQ-028 SHALL ignore op_valid outside IDLE, with no queuing.
REQ-029 SHALL give abort priority over acceptance when abort and op_valid are high together in IDLE: the request is not accepted.

Reset
REQ-030 SHALL, on rst high at a rising edge, set state=IDLE, hi=0, lo=0, counter=0, done=0, div_by_zero=0; op_ready=1 and busy=0 in the following cycle.
REQ-031 SHALL let rst override abort and op_valid, including mid-operation.

Configuration
REQ-032 SHALL, when MULDIV_DIV_EN is defined, compile in the divide path: DIV/DIVU behave as in REQ-022..024.
REQ-033 SHALL, when MULDIV_DIV_EN is undefined, omit the divide datapath, treat DIV/DIVU as unrecognised (REQ-025) and tie div_by_zero to 0.

Structure
REQ-034 SHALL take the funct code constants and the state enum type from shared package mips_pkg, shared with the ALU and decoder.
REQ-035 SHALL place the iteration datapath (shift-add / restore-subtract registers, magnitude and sign logic) in sub-module muldiv_dp; muldiv_seq holds the FSM, counter, handshake and HI/LO.

Verification
REQ-036 SHALL cover MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done at W+2 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 SHALL cover MULT A=-3, B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 SHALL cover DIVU A=100, B=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1 with done.
REQ-039 SHALL cover MULT issued, then abort in CALC cycle 10 -> IDLE next cycle, no done, hi/lo keep prior values; also op_valid with abort in IDLE -> not accepted.
REQ-040 SHALL cover MTLO 0x1234 then MTHI 0x5678 back-to-back -> lo=0x1234, hi=0x5678, op_ready stays 1, no done.
REQ-041 SHALL cover rst asserted in CALC -> next cycle state IDLE, hi=lo=0, busy=0; and, without MULDIV_DIV_EN, DIV -> no done.
